cms_addsub_arbiter: RTL and testbench

CMS_ADDSUB_ARBITER -- requirements
Module: cms_addsub_arbiter

---
 rtl/cms_addsub_arbiter.sv | 103 ++++++++++
 tb/tb_cms_addsub_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cms_addsub_arbiter.sv
// Two-requester round-robin arbiter feeding a registered packed-complex add/sub unit.
// Optional macro CMS_ADDSUB_OVF_EN adds the res_ovf port with per-half signed overflow flags.
module cms_addsub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_add_not_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_add_not_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef CMS_ADDSUB_OVF_EN
  output logic [1:0]       res_ovf,
`endif
  output logic             res_id
);

  localparam int H = WIDTH / 2;

  logic             load;
  logic             xfer;
  logic             last_grant;
  logic [1:0]       grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_add;
  logic [H-1:0]     a_re, a_im, b_re, b_im;
  logic [H-1:0]     r_re, r_im;

  // last_grant names the requester that won the most recent transfer
  always_comb begin
    grant = 2'b00;
    if (req0_valid && req1_valid)
      grant = last_grant ? 2'b01 : 2'b10;
    else if (req0_valid)
      grant = 2'b01;
    else if (req1_valid)
      grant = 2'b10;
  end

  assign load       = !res_valid || res_ready;
  assign req0_ready = rst_n && load && grant[0];
  assign req1_ready = rst_n && load && grant[1];
  assign xfer       = req0_ready || req1_ready;

  assign op_a   = grant[1] ? req1_a : req0_a;
  assign op_b   = grant[1] ? req1_b : req0_b;
  assign op_add = grant[1] ? req1_add_not_sub : req0_add_not_sub;

  assign a_re = op_a[WIDTH-1:H];
  assign a_im = op_a[H-1:0];
  assign b_re = op_b[WIDTH-1:H];
  assign b_im = op_b[H-1:0];

  // halves are computed separately so no carry or borrow crosses between them
  assign r_re = op_add ? (a_re + b_re) : (a_re - b_re);
  assign r_im = op_add ? (a_im + b_im) : (a_im - b_im);

`ifdef CMS_ADDSUB_OVF_EN
  logic [1:0] nxt_ovf;

  function automatic logic ovf_bit(input logic sa, input logic sb, input logic sr,
                                   input logic add);
    return add ? ((sa == sb) && (sr != sa)) : ((sa != sb) && (sr != sa));
  endfunction

  assign nxt_ovf = {ovf_bit(a_re[H-1], b_re[H-1], r_re[H-1], op_add),
                    ovf_bit(a_im[H-1], b_im[H-1], r_im[H-1], op_add)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      res_ovf <= 2'b00;
    else if (xfer)
      res_ovf <= nxt_ovf;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      res_valid  <= 1'b1;
      res_data   <= {r_re, r_im};
      res_id     <= grant[1];
      last_grant <= grant[1];
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cms_addsub_arbiter.sv
// Self-checking bench for cms_addsub_arbiter (WIDTH=32): directed table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_cms_addsub_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_add_not_sub, req1_add_not_sub;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic [1:0]       res_ovf;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_id;
  logic [1:0]  m_ovf;
  int          m_last;

  typedef struct {
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic        add;
    logic [31:0] exp_data;
    logic [1:0]  exp_ovf;
  } vec_t;

  vec_t tbl[6];

  cms_addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0_valid       (req0_valid),
    .req0_ready       (req0_ready),
    .req0_a           (req0_a),
    .req0_b           (req0_b),
    .req0_add_not_sub (req0_add_not_sub),
    .req1_valid       (req1_valid),
    .req1_ready       (req1_ready),
    .req1_a           (req1_a),
    .req1_b           (req1_b),
    .req1_add_not_sub (req1_add_not_sub),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
`ifdef CMS_ADDSUB_OVF_EN
    .res_ovf          (res_ovf),
`endif
    .res_id           (res_id)
  );

`ifndef CMS_ADDSUB_OVF_EN
  assign res_ovf = 2'b00;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // true signed arithmetic per half; overflow when the exact result leaves the 16-bit range
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b, input logic add,
                                   output logic [31:0] d, output logic [1:0] o);
    int ar, ai, br, bi, rr, ri;
    logic [31:0] rrv, riv;
    ar = $signed(a[31:16]);
    ai = $signed(a[15:0]);
    br = $signed(b[31:16]);
    bi = $signed(b[15:0]);
    rr = add ? ar + br : ar - br;
    ri = add ? ai + bi : ai - bi;
    rrv = rr;
    riv = ri;
    d = {rrv[15:0], riv[15:0]};
    o = {(rr > 32767 || rr < -32768), (ri > 32767 || ri < -32768)};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 1'b0;
    m_ovf   = 2'b00;
    m_last  = 1;
  endtask

  // Called just after a rising edge with inputs already driven; advances one clock.
  task automatic cycle();
    int   win;
    logic ld, xf;
    @(negedge clk);
    ld  = !m_valid || res_ready;
    win = -1;
    if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
    else if (req0_valid)          win = 0;
    else if (req1_valid)          win = 1;
    xf = ld && (win >= 0);
    chk("req0_ready", req0_ready, ld && (win == 0));
    chk("req1_ready", req1_ready, ld && (win == 1));
    @(posedge clk);
    #1;
    if (xf) begin
      if (win == 0) model_op(req0_a, req0_b, req0_add_not_sub, m_data, m_ovf);
      else          model_op(req1_a, req1_b, req1_add_not_sub, m_data, m_ovf);
      m_valid = 1'b1;
      m_id    = (win == 1);
      m_last  = win;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    chk("res_valid", res_valid, m_valid);
    chk("res_data", res_data, m_data);
    chk("res_id", res_id, m_id);
`ifdef CMS_ADDSUB_OVF_EN
    chk("res_ovf", res_ovf, m_ovf);
`endif
  endtask

  initial begin
    tbl[0] = '{1'b0, 32'h0003_0005, 32'h0001_0002, 1'b1, 32'h0004_0007, 2'b00};
    tbl[1] = '{1'b1, 32'h0001_0000, 32'h0002_0001, 1'b0, 32'hFFFF_FFFF, 2'b00};
    tbl[2] = '{1'b0, 32'h7FFF_0000, 32'h0001_0000, 1'b1, 32'h8000_0000, 2'b10};
    tbl[3] = '{1'b1, 32'h8000_0005, 32'h0001_0007, 1'b0, 32'h7FFF_FFFE, 2'b10};
    tbl[4] = '{1'b0, 32'h0001_7FFF, 32'h0000_0001, 1'b1, 32'h0001_8000, 2'b01};
    tbl[5] = '{1'b1, 32'hFFFF_8000, 32'hFFFF_8000, 1'b1, 32'hFFFE_0000, 2'b01};

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h0001_0001; req0_b = 32'h0001_0001; req0_add_not_sub = 1'b1;
    req1_a = 32'h0002_0002; req1_b = 32'h0001_0001; req1_add_not_sub = 1'b0;
    res_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
`ifdef CMS_ADDSUB_OVF_EN
    chk("rst_res_ovf", res_ovf, 2'b00);
`endif
    rst_n = 1'b1;

    // contention right after reset: requester 0 first, then alternate
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("contention_id", res_id, i % 2);
    end

    // backpressure with both requesters waiting
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_valid_held", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_one_ready", req0_ready ^ req1_ready, 1'b1);
    @(posedge clk);
    #1;
    // keep the model aligned: contention continues alternating (last winner was 1)
    model_op(req0_a, req0_b, req0_add_not_sub, m_data, m_ovf);
    m_valid = 1'b1; m_id = 1'b0; m_last = 0;
    chk("bp_release_id", res_id, 1'b0);
    chk("bp_release_data", res_data, m_data);

    // directed table, one requester at a time
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].req) begin
        req1_valid = 1'b1; req1_a = tbl[i].a; req1_b = tbl[i].b;
        req1_add_not_sub = tbl[i].add;
      end else begin
        req0_valid = 1'b1; req0_a = tbl[i].a; req0_b = tbl[i].b;
        req0_add_not_sub = tbl[i].add;
      end
      cycle();
      chk("tbl_data", res_data, tbl[i].exp_data);
      chk("tbl_id", res_id, tbl[i].req);
`ifdef CMS_ADDSUB_OVF_EN
      chk("tbl_ovf", res_ovf, tbl[i].exp_ovf);
`endif
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    cycle();
    chk("idle_clears_valid", res_valid, 1'b0);

    // reset while a result is held under backpressure
    req0_valid = 1'b1; req0_a = 32'h0010_0020; req0_b = 32'h0001_0002; req0_add_not_sub = 1'b1;
    cycle();
    req0_valid = 1'b0;
    res_ready = 1'b0;
    cycle();
    chk("midop_held", res_valid, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_valid", res_valid, 1'b0);
    chk("midop_rst_req0_ready", req0_ready, 1'b0);
    chk("midop_rst_req1_ready", req1_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    cycle();
    chk("post_rst_no_result", res_valid, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycle();
    chk("post_rst_first_grant", res_id, 1'b0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom; req0_b = $urandom; req0_add_not_sub = 1'($urandom_range(0, 1));
      req1_a = $urandom; req1_b = $urandom; req1_add_not_sub = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
